// File: rtl/paddle_pkg.sv
// Shared types and constants for the paddle quadrature generator.
// Optional mouse path is compiled in with PADDLE_MOUSE_EN.
package paddle_pkg;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_LEFT  = 2'd2
  } dir_t;

  // Gray successor tables indexed by the current phase.
  localparam logic [3:0][1:0] QUAD_NEXT_R = {2'b10, 2'b00, 2'b11, 2'b01};
  localparam logic [3:0][1:0] QUAD_NEXT_L = {2'b01, 2'b11, 2'b00, 2'b10};

  // The 16th consecutive step in one direction raises the speed level.
  localparam logic [3:0] ACCEL_LAST_STEP = 4'd15;

  function automatic int acc_sat_lim(input int acc_w);
    return (1 << (acc_w - 1)) - 1;
  endfunction

  function automatic dir_t resolve_dir(input logic left, input logic right);
    dir_t d;
    d = DIR_NONE;
    if (right && !left) d = DIR_RIGHT;
    else if (left && !right) d = DIR_LEFT;
    return d;
  endfunction

endpackage

// File: rtl/paddle_quad_gen_if.sv
// Paddle input/quadrature output bundle; mouse signals exist only with PADDLE_MOUSE_EN.
// mouse_stb is a valid-only strobe with no ready: every strobe is accepted in its cycle.
interface paddle_quad_gen_if;
  logic              left;
  logic              right;
`ifdef PADDLE_MOUSE_EN
  logic signed [8:0] mouse_dx;
  logic              mouse_stb;
`endif
  logic [1:0]        steer;
  logic              moving;

  modport master (
`ifdef PADDLE_MOUSE_EN
    output mouse_dx, mouse_stb,
`endif
    output left, right,
    input  steer, moving
  );

  modport slave (
`ifdef PADDLE_MOUSE_EN
    input  mouse_dx, mouse_stb,
`endif
    input  left, right,
    output steer, moving
  );
endinterface

// File: rtl/quad_phase_step.sv
// Two-bit Gray phase register: advances one Gray state per step in the given direction.
module quad_phase_step
  import paddle_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       step_i,
  input  dir_t       dir_i,
  output logic [1:0] phase_o
);

  logic [1:0] phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (step_i) begin
      case (dir_i)
        DIR_RIGHT: phase_d = QUAD_NEXT_R[phase_q];
        DIR_LEFT:  phase_d = QUAD_NEXT_L[phase_q];
        default:   phase_d = phase_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) phase_q <= 2'b00;
    else       phase_q <= phase_d;
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/paddle_quad_gen.sv
// Digital paddle to quadrature encoder emulation with hold-to-accelerate stepping.
// Define PADDLE_MOUSE_EN to add the mouse delta accumulator and its step path.
module paddle_quad_gen
  import paddle_pkg::*;
#(
  parameter int CLKDIV      = 5500,
  parameter int ACCEL_STEPS = 4
`ifdef PADDLE_MOUSE_EN
  ,
  parameter int ACC_W       = 10
`endif
) (
  input logic              clk_sys,
  input logic              reset,
  paddle_quad_gen_if.slave pad
);

  localparam int CNT_W = $clog2(CLKDIV + 1);
  localparam int LVL_W = (ACCEL_STEPS > 1) ? $clog2(ACCEL_STEPS) : 1;
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(ACCEL_STEPS - 1);

  // Counter reload value: period minus one gives exactly one period between steps.
  function automatic logic [CNT_W-1:0] load_for(input logic [LVL_W-1:0] lvl);
    int period;
    period = CLKDIV >> lvl;
    return (period > 0) ? CNT_W'(period - 1) : '0;
  endfunction

  localparam logic [CNT_W-1:0] FAST_LOAD = load_for(LVL_MAX);

  logic             left_q, right_q;
  dir_t             prev_dir_q;
  logic [LVL_W-1:0] level_q, level_d, lvl_cur;
  logic [3:0]       stepcnt_q, stepcnt_d, stepcnt_cur;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dir_t             joy_dir, mouse_dir, step_dir;
  logic             dir_change, accel_clr, fire;
  logic [1:0]       steer;

  assign joy_dir    = resolve_dir(left_q, right_q);
  assign dir_change = (joy_dir != prev_dir_q);

`ifdef PADDLE_MOUSE_EN
  localparam int SUM_W = ACC_W + 2;
  localparam logic signed [SUM_W-1:0] LIM_P = SUM_W'(acc_sat_lim(ACC_W));
  localparam logic signed [SUM_W-1:0] LIM_N = -LIM_P;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [SUM_W-1:0] acc_sum;

  always_comb begin
    mouse_dir = DIR_NONE;
    if (acc_q != '0) mouse_dir = acc_q[ACC_W-1] ? DIR_LEFT : DIR_RIGHT;
  end

  // Strobe and drain step fold into one saturating update.
  always_comb begin
    acc_sum = SUM_W'(acc_q);
    if (pad.mouse_stb) acc_sum = acc_sum + SUM_W'(pad.mouse_dx);
    if (fire && (joy_dir == DIR_NONE)) begin
      if (mouse_dir == DIR_RIGHT) acc_sum = acc_sum - SUM_W'(1);
      else                        acc_sum = acc_sum + SUM_W'(1);
    end
    if (acc_sum > LIM_P)      acc_d = ACC_W'(LIM_P);
    else if (acc_sum < LIM_N) acc_d = ACC_W'(LIM_N);
    else                      acc_d = ACC_W'(acc_sum);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign pad.moving = (joy_dir != DIR_NONE) || (acc_q != '0);
`else
  assign mouse_dir  = DIR_NONE;
  assign pad.moving = (joy_dir != DIR_NONE);
`endif

  always_comb begin
    step_dir = mouse_dir;
    if (joy_dir != DIR_NONE) step_dir = joy_dir;
    fire        = (step_dir != DIR_NONE) && (dir_change || (cnt_q == '0));
    accel_clr   = (joy_dir == DIR_NONE) || dir_change;
    lvl_cur     = accel_clr ? '0 : level_q;
    stepcnt_cur = accel_clr ? '0 : stepcnt_q;
    level_d     = lvl_cur;
    stepcnt_d   = stepcnt_cur;
    cnt_d       = (dir_change || (cnt_q == '0)) ? '0 : cnt_q - CNT_W'(1);
    if (fire) begin
      if (joy_dir != DIR_NONE) begin
        // Reload uses the level in force before this step's increment.
        cnt_d = load_for(lvl_cur);
        if (stepcnt_cur == ACCEL_LAST_STEP) begin
          stepcnt_d = '0;
          if (lvl_cur != LVL_MAX) level_d = lvl_cur + LVL_W'(1);
        end else begin
          stepcnt_d = stepcnt_cur + 4'd1;
        end
      end else begin
        cnt_d = FAST_LOAD;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      left_q     <= 1'b0;
      right_q    <= 1'b0;
      prev_dir_q <= DIR_NONE;
      level_q    <= '0;
      stepcnt_q  <= '0;
      cnt_q      <= '0;
    end else begin
      left_q     <= pad.left;
      right_q    <= pad.right;
      prev_dir_q <= joy_dir;
      level_q    <= level_d;
      stepcnt_q  <= stepcnt_d;
      cnt_q      <= cnt_d;
    end
  end

  quad_phase_step u_phase (
    .clk_i   (clk_sys),
    .rst_i   (reset),
    .step_i  (fire),
    .dir_i   (step_dir),
    .phase_o (steer)
  );

  assign pad.steer = steer;

endmodule
